// File: rtl/var_bw_mul_pipe.sv
// Pipelined variable bit-width multiplier: one full, two half or four quarter lanes,
// signed or unsigned, with a LAT-deep valid/ready pipeline that stalls as a whole.
module var_bw_mul_pipe #(
  parameter int WIDTH = 16,
  parameter int LAT   = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         mode,
  input  logic               sgn,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               err
);

  localparam int H = WIDTH / 2;
  localparam int Q = WIDTH / 4;

  logic [2*WIDTH-1:0] full_s;
  logic [2*WIDTH-1:0] half_s;
  logic [2*WIDTH-1:0] quarter_s;
  logic [2*WIDTH-1:0] prod_s;
  logic               ill_s;
  logic               advance_s;

  logic [LAT-1:0]                    v_r;
  logic [LAT-1:0]                    e_r;
  logic [LAT-1:0][2*WIDTH-1:0]       d_r;

  // Each lane is extended to twice its width so the truncated product is exact
  // for both signed and unsigned operands, and nothing crosses a lane boundary.
  logic [2*WIDTH-1:0] full_xe_s;
  logic [2*WIDTH-1:0] full_ye_s;
  assign full_xe_s = {{WIDTH{sgn & a[WIDTH-1]}}, a};
  assign full_ye_s = {{WIDTH{sgn & b[WIDTH-1]}}, b};
  assign full_s    = full_xe_s * full_ye_s;

  for (genvar g = 0; g < 2; g++) begin : g_half
    logic [WIDTH-1:0] xe_s;
    logic [WIDTH-1:0] ye_s;
    assign xe_s = {{H{sgn & a[g*H+H-1]}}, a[g*H +: H]};
    assign ye_s = {{H{sgn & b[g*H+H-1]}}, b[g*H +: H]};
    assign half_s[g*WIDTH +: WIDTH] = xe_s * ye_s;
  end

  for (genvar g = 0; g < 4; g++) begin : g_quarter
    logic [H-1:0] xe_s;
    logic [H-1:0] ye_s;
    assign xe_s = {{Q{sgn & a[g*Q+Q-1]}}, a[g*Q +: Q]};
    assign ye_s = {{Q{sgn & b[g*Q+Q-1]}}, b[g*Q +: Q]};
    assign quarter_s[g*H +: H] = xe_s * ye_s;
  end

  // Select the product for the requested mode; the illegal mode yields zero with err.
  always_comb begin
    prod_s = {2*WIDTH{1'b0}};
    ill_s  = 1'b0;
    case (mode)
      2'b00:   prod_s = full_s;
      2'b01:   prod_s = half_s;
      2'b10:   prod_s = quarter_s;
      default: begin
        prod_s = {2*WIDTH{1'b0}};
        ill_s  = 1'b1;
      end
    endcase
  end

  assign advance_s = ~v_r[LAT-1] | out_ready;
  assign in_ready  = advance_s;

  // Pipeline chain: every stage shifts together on advance, otherwise all hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_r <= {LAT{1'b0}};
      e_r <= {LAT{1'b0}};
      d_r <= {LAT{{2*WIDTH{1'b0}}}};
    end else if (advance_s) begin
      v_r[0] <= in_valid;
      e_r[0] <= in_valid & ill_s;
      d_r[0] <= in_valid ? prod_s : {2*WIDTH{1'b0}};
      for (int i = 1; i < LAT; i++) begin
        v_r[i] <= v_r[i-1];
        e_r[i] <= e_r[i-1];
        d_r[i] <= d_r[i-1];
      end
    end
  end

  assign out_valid = v_r[LAT-1];
  assign err       = e_r[LAT-1];
  assign p         = d_r[LAT-1];

endmodule

// File: tb/tb_var_bw_mul_pipe.sv
// Self-checking bench for var_bw_mul_pipe: scoreboard of modelled results plus
// per-scenario latency, ordering, backpressure and reset checks.
module tb_var_bw_mul_pipe;

  localparam int WIDTH = 16;
  localparam int LAT   = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [1:0]        mode = 2'b00;
  logic              sgn = 1'b0;
  logic [WIDTH-1:0]  a = '0;
  logic [WIDTH-1:0]  b = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [2*WIDTH-1:0] p;
  logic              err;

  int tests = 0;
  int fails = 0;
  int delivered = 0;
  logic [32:0] sb[$];

  var_bw_mul_pipe #(.WIDTH(WIDTH), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .sgn(sgn), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .p(p), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference: each lane sign/zero extended as an integer, product masked to its field.
  function automatic logic [32:0] model(logic [15:0] x, logic [15:0] y, logic [1:0] m, logic s);
    int L;
    longint r, ux, uy, pr, mask;
    r = 0;
    if (m == 2'b11) return {1'b1, 32'h0000_0000};
    L = (m == 2'b00) ? 16 : (m == 2'b01) ? 8 : 4;
    mask = (64'sd1 <<< L) - 64'sd1;
    for (int i = 0; i < 16 / L; i++) begin
      ux = (longint'(x) >> (i * L)) & mask;
      uy = (longint'(y) >> (i * L)) & mask;
      if (s && ux[L-1]) ux = ux - (64'sd1 <<< L);
      if (s && uy[L-1]) uy = uy - (64'sd1 <<< L);
      pr = (ux * uy) & ((64'sd1 <<< (2 * L)) - 64'sd1);
      r  = r | (pr << (i * 2 * L));
    end
    return {1'b0, r[31:0]};
  endfunction

  // Scoreboard: push on accept, pop and compare on deliver, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready) sb.push_back(model(a, b, mode, sgn));
      if (out_valid && out_ready) begin
        tests++;
        delivered++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL sb_unexpected: got p=%h err=%b, required no result", p, err);
        end else begin
          if ({err, p} !== sb[0]) begin
            fails++;
            $display("FAIL sb_result: got err=%b p=%h, required err=%b p=%h",
                     err, p, sb[0][32], sb[0][31:0]);
          end
          void'(sb.pop_front());
        end
      end
    end
  end

  task automatic send(input logic [15:0] ta, input logic [15:0] tb_v, input logic [1:0] tm, input logic ts);
    int k;
    k = 0;
    in_valid = 1'b1; a = ta; b = tb_v; mode = tm; sgn = ts;
    do begin
      @(negedge clk);
      k++;
    end while (!in_ready && k < 100);
    tests++;
    if (!in_ready) begin
      fails++;
      $display("FAIL send_timeout: in_ready=%b, required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Called right after an accept edge; counts cycles until out_valid and checks p/err.
  task automatic wait_result(input string name, input logic [31:0] exp_p, input logic exp_e);
    int k;
    k = 1;
    @(negedge clk);
    while (!out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    tests++;
    if (k !== LAT) begin
      fails++;
      $display("FAIL %s_latency: got %0d cycles, required %0d", name, k, LAT);
    end
    tests++;
    if (p !== exp_p || err !== exp_e) begin
      fails++;
      $display("FAIL %s_value: got p=%h err=%b, required p=%h err=%b", name, p, err, exp_p, exp_e);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    #1;
    tests++;
    if (out_valid !== 1'b0 || p !== 32'h0 || err !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: got v=%b p=%h err=%b, required 0 0 0", out_valid, p, err);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_in_ready: got %b, required 1", in_ready);
    end
  endtask

  task automatic test_full;
    out_ready = 1'b1;
    send(16'hFFFF, 16'hFFFF, 2'b00, 1'b0);
    wait_result("full_unsigned", 32'hFFFE_0001, 1'b0);
  endtask

  task automatic test_two_lanes;
    send(16'h12FF, 16'h03FF, 2'b01, 1'b0);
    wait_result("two_lanes", 32'h0036_FE01, 1'b0);
  endtask

  task automatic test_back_to_back;
    int k;
    out_ready = 1'b1;
    send(16'hF278, 16'hF378, 2'b10, 1'b1);
    send(16'hFFFF, 16'h0002, 2'b00, 1'b1);
    send(16'h1234, 16'h5678, 2'b11, 1'b0);
    k = 0;
    @(negedge clk);
    while (!out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    tests++;
    if (out_valid !== 1'b1 || p !== 32'h0106_3140 || err !== 1'b0) begin
      fails++;
      $display("FAIL b2b_first: got v=%b p=%h err=%b, required 1 01063140 0", out_valid, p, err);
    end
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b1 || p !== 32'hFFFF_FFFE || err !== 1'b0) begin
      fails++;
      $display("FAIL b2b_second: got v=%b p=%h err=%b, required 1 fffffffe 0", out_valid, p, err);
    end
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b1 || p !== 32'h0 || err !== 1'b1) begin
      fails++;
      $display("FAIL b2b_illegal: got v=%b p=%h err=%b, required 1 00000000 1", out_valid, p, err);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    logic [15:0] ta[5] = '{16'h1234, 16'hFFFF, 16'h8001, 16'h7F80, 16'hA5A5};
    logic [15:0] tv[5] = '{16'h0003, 16'h8000, 16'h00FF, 16'h8181, 16'h5A5A};
    logic [1:0]  tm[5] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10};
    logic        ts[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    int idx, cyc, d0;
    logic acc;
    logic [31:0] held;
    idx = 0;
    d0 = delivered;
    out_ready = 1'b0;
    in_valid = 1'b1; a = ta[0]; b = tv[0]; mode = tm[0]; sgn = ts[0];
    for (cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (cyc == 3) begin
        held = p;
        tests++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || idx !== 3) begin
          fails++;
          $display("FAIL bp_full: got v=%b in_ready=%b accepted=%0d, required 1 0 3", out_valid, in_ready, idx);
        end
      end
      if (cyc == 5) begin
        tests++;
        if (p !== held || in_ready !== 1'b0 || idx !== 3) begin
          fails++;
          $display("FAIL bp_hold: got p=%h in_ready=%b accepted=%0d, required p=%h 0 3", p, in_ready, idx, held);
        end
      end
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        if (idx < 5) begin
          a = ta[idx]; b = tv[idx]; mode = tm[idx]; sgn = ts[idx];
        end else begin
          in_valid = 1'b0;
        end
      end
      if (cyc == 5) out_ready = 1'b1;
      if (cyc == 5) d0 = delivered;
      if (cyc == 10) break;
    end
    tests++;
    if (delivered - d0 !== 5 || sb.size() !== 0 || idx !== 5) begin
      fails++;
      $display("FAIL bp_drain: got %0d delivered in 5 cycles, %0d pending, %0d accepted, required 5 0 5",
               delivered - d0, sb.size(), idx);
    end
  endtask

  task automatic test_midflight_reset;
    int seen;
    out_ready = 1'b1;
    send(16'h0101, 16'h0202, 2'b00, 1'b0);
    send(16'h0303, 16'h0404, 2'b01, 1'b0);
    #1 rst = 1'b1;
    sb.delete();
    #1;
    tests++;
    if (out_valid !== 1'b0 || p !== 32'h0 || err !== 1'b0) begin
      fails++;
      $display("FAIL rst_flush: got v=%b p=%h err=%b, required 0 0 0", out_valid, p, err);
    end
    #1 rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    tests++;
    if (seen !== 0) begin
      fails++;
      $display("FAIL rst_stale: got %0d stale results, required 0", seen);
    end
    @(posedge clk); #1;
    send(16'h00F0, 16'h0010, 2'b00, 1'b0);
    wait_result("rst_after", 32'h0000_0F00, 1'b0);
  endtask

  initial begin
    test_reset();
    test_full();
    test_two_lanes();
    test_back_to_back();
    test_backpressure();
    test_midflight_reset();
    repeat (4) @(negedge clk);
    tests++;
    if (sb.size() !== 0) begin
      fails++;
      $display("FAIL sb_leftover: got %0d pending results, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/var_bw_mul_pipe.md
# var_bw_mul_pipe

Pipelined, parametrised variable bit-width multiplier with valid/ready handshakes. Each operation multiplies two WIDTH-bit operands in one of three modes: one WIDTH×WIDTH product, two parallel (WIDTH/2)-bit lane products, or four parallel (WIDTH/4)-bit lane products. Each operation also selects signed or unsigned arithmetic. The block sits between an operand-issue stage and a result consumer, and it stalls as a whole under backpressure.

## Interface
- WIDTH, 16: operand width; must be a multiple of 4 and ≥ 8.
- LAT, 3: pipeline depth in register stages; must be ≥ 1.
- clk  in  1  clock; all registers rise-edge triggered.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand transfer request.
- in_ready  out  1  block can accept an operand transfer this cycle.
- mode  in  2  00 full, 01 two lanes, 10 four lanes, 11 illegal.
- sgn  in  1  1: each lane is two's complement; 0: unsigned.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- out_valid  out  1  result present on p/err.
- out_ready  in  1  consumer accepts the result this cycle.
- p  out  2*WIDTH  product vector.
- err  out  1  the result came from an illegal mode.

## Operation
- Lane definitions:
  - Mode 00: one lane; a, b full width; p holds the whole 2*WIDTH product.
  - Mode 01: lane i (i=0,1) uses a[i*W/2 +: W/2] and b likewise; its product occupies p[i*W +: W].
  - Mode 10: lane i (i=0..3) uses a[i*W/4 +: W/4]; its product occupies p[i*W/2 +: W/2].
- Lane products are exact. No truncation is possible: each lane's output field is exactly twice the lane operand width.
- Sign handling:
  - sgn=1: each lane operand is sign-extended from its own MSB, and the product is a two's-complement field within its lane.
  - No carry or sign bit crosses a lane boundary.
- mode=11: the operation is accepted normally and travels through the pipeline. Its result has p=0 and err=1.
- err=0 for all legal modes.
- Operand, mode and sgn are captured together at the accept edge. Changing inputs after acceptance has no effect on that operation.
- Pipeline control:
  - The pipeline is a chain of LAT stages, each with a valid bit.
  - advance = !v[LAT-1] | out_ready.
  - When advance=1, every stage shifts by one. Stage 0 loads the new operation if in_valid, otherwise a bubble.
  - When advance=0, all stages hold.
  - in_ready = advance. This is combinational, and in_ready does not depend on in_valid.
- Bubbles are not compacted. A hold freezes the whole chain.
- Results leave in acceptance order. No result is lost or duplicated.
- Internal partitioning of the multiply across stages is free, provided the required latency and results are met.

## Timing
- Reset (async assert, sync release): all stage valid bits are cleared.
  - out_valid=0, p=0, err=0.
  - in_ready=1 from the first cycle after reset release.
- A reset mid-operation discards every in-flight operation. No result from before the reset ever appears.
- Transfer in: in_valid & in_ready at a rising edge. A transfer presented in cycle n appears on out_valid/p/err in cycle n+LAT, provided no stall occurs in between.
- Transfer out: out_valid & out_ready at a rising edge.
- While out_valid=1 and out_ready=0, the output fields are stable.
- Full throughput: one accept and one deliver per cycle when out_ready is held at 1.
- Simultaneous deliver and accept in the same cycle is allowed. With LAT=1 and out_ready=1, the new result replaces the delivered one at that edge.
- Maximum occupancy is LAT operations. With out_ready=0, in_ready falls in the same cycle that out_valid rises.
- Outputs are registered. out_valid and p/err come directly from the final stage registers.

## Test plan
- **Full unsigned** (WIDTH=16, LAT=3): mode=00, sgn=0, a=0xFFFF, b=0xFFFF → p=0xFFFE0001, err=0, 3 cycles after accept.
- **Two lanes unsigned**: mode=01, sgn=0, a=0x12FF, b=0x03FF → p=0x0036FE01.
- **Four lanes signed, full signed, illegal mode** (issued back-to-back with out_ready=1, so all three are accepted in consecutive cycles):
  - mode=10, sgn=1, a=0xF278, b=0xF378 → p=0x01063140.
  - mode=00, sgn=1, a=0xFFFF, b=0x0002 → p=0xFFFFFFFE.
  - mode=11 → p=0, err=1.
  - The three results must appear in three consecutive cycles.
- **Backpressure**: accept 5 operations back-to-back with out_ready=0.
  - Exactly 3 are accepted, and in_ready falls when the first reaches the output.
  - Raise out_ready: the results drain in order, one per cycle, the remaining 2 are then accepted, and all 5 products are correct.
- **Mid-flight reset**: accept 2 operations, then pulse rst between edges.
  - out_valid=0 and p=0 immediately.
  - After release, no stale result appears, and the next operation completes with normal latency.
